// File: rtl/mem_bist_pkg.sv
// mem_bist_pkg: shared types and constants for the memory self-test engine.
// Holds the controller state encoding, pattern mode encodings and the width
// of the saturating mismatch counter.
package mem_bist_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HOLD  = 3'd1,
    WRITE = 3'd2,
    READ  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [1:0] MODE_INV_IDX = 2'd0;
  localparam logic [1:0] MODE_IDX     = 2'd1;
  localparam logic [1:0] MODE_CHECKER = 2'd2;
  localparam logic [1:0] MODE_WALK1   = 2'd3;

  localparam int                   ERR_CNT_W   = 16;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

endpackage

// File: rtl/mem_bist_pattern.sv
// mem_bist_pattern: combinational test pattern generator P(i).
// One instance feeds both the write data path and the read-back comparator,
// so written and expected data can never disagree.
module mem_bist_pattern
  import mem_bist_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IDX_W      = 16
) (
  input  logic [1:0]            mode,
  input  logic [IDX_W-1:0]      idx,
  input  logic                  addr_lsb,
  output logic [DATA_WIDTH-1:0] pat
);

  logic [DATA_WIDTH-1:0] idx_t;
  logic [DATA_WIDTH-1:0] chk_pat;
  logic [DATA_WIDTH-1:0] walk_pat;
  int unsigned           walk_pos;

  // Build all four candidate patterns and select one by mode
  always_comb begin
    idx_t    = DATA_WIDTH'(idx);
    walk_pos = 32'(idx) % 32'(DATA_WIDTH);
    for (int k = 0; k < DATA_WIDTH; k++) begin
      // 0101... (bit 0 set) on even addresses, inverted on odd ones
      chk_pat[k]  = (k[0] == 1'b0) ^ addr_lsb;
      walk_pat[k] = (walk_pos == 32'(k));
    end
    case (mode)
      MODE_INV_IDX: pat = ~idx_t;
      MODE_IDX:     pat = idx_t;
      MODE_CHECKER: pat = chk_pat;
      default:      pat = walk_pat;
    endcase
  end

endmodule

// File: rtl/mem_bist.sv
// mem_bist: hardware memory self-test engine acting as a second RAM bus master.
// On start it holds the CPU, writes a pattern across the address window,
// reads it back, compares, and reports pass/fail.
// Build option MEM_BIST_ERR_LOG_EN: when defined, a saturating mismatch
// counter and first-mismatch address/data capture are implemented; otherwise
// those outputs read 0 and only a sticky mismatch flag drives pass.
module mem_bist
  import mem_bist_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 32768,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            mode,
  output logic                  busy,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_oe,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [ERR_CNT_W-1:0]  err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic [DATA_WIDTH-1:0] first_err_data
);

  localparam int                    IDX_W    = $clog2(DEPTH) + 1;
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);

  state_t                state;
  logic [IDX_W-1:0]      idx;
  logic [1:0]            mode_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  pass_q;
  logic                  err_flag;

  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] pat;
  logic                  in_write;
  logic                  in_read;
  logic                  last;
  logic                  accept;
  logic                  mismatch;

  assign win_addr = BASE + ADDR_WIDTH'(idx);
  assign in_write = (state == WRITE);
  assign in_read  = (state == READ);
  assign last     = (idx == LAST_IDX);
  // start is only honoured while the engine is not running
  assign accept   = start && ((state == IDLE) || (state == DONE));
  assign mismatch = in_read && (mem_rdata != pat);

  mem_bist_pattern #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_pattern (
    .mode     (mode_q),
    .idx      (idx),
    .addr_lsb (win_addr[0]),
    .pat      (pat)
  );

  // Bus outputs decode directly from the state register; strobes are
  // mutually exclusive by construction and the bus is idle outside WRITE/READ
  assign mem_we    = in_write;
  assign mem_oe    = in_read;
  assign mem_addr  = (in_write || in_read) ? win_addr : '0;
  assign mem_wdata = in_write ? pat : '0;

  assign busy     = busy_q;
  assign cpu_hold = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;

  // Test sequencer: IDLE -> HOLD -> WRITE sweep -> READ sweep -> DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      mode_q   <= MODE_INV_IDX;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_flag <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            mode_q   <= mode;
            idx      <= '0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_flag <= 1'b0;
            state    <= HOLD;
          end
        end
        HOLD: begin
          state <= WRITE;
        end
        WRITE: begin
          if (last) begin
            idx   <= '0;
            state <= READ;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        READ: begin
          if (mismatch) begin
            err_flag <= 1'b1;
          end
          if (last) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            // include the compare happening on this final edge
            pass_q <= !(err_flag || mismatch);
            state  <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef MEM_BIST_ERR_LOG_EN
  logic [ERR_CNT_W-1:0]  err_cnt_q;
  logic [ADDR_WIDTH-1:0] err_addr_q;
  logic [DATA_WIDTH-1:0] err_data_q;

  // Saturating mismatch counter plus capture of the first failing word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt_q  <= '0;
      err_addr_q <= '0;
      err_data_q <= '0;
    end else if (accept) begin
      err_cnt_q  <= '0;
      err_addr_q <= '0;
      err_data_q <= '0;
    end else if (mismatch) begin
      if (err_cnt_q != ERR_CNT_MAX) begin
        err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
      end
      if (!err_flag) begin
        err_addr_q <= win_addr;
        err_data_q <= mem_rdata;
      end
    end
  end

  assign err_count      = err_cnt_q;
  assign first_err_addr = err_addr_q;
  assign first_err_data = err_data_q;
`else
  assign err_count      = '0;
  assign first_err_addr = '0;
  assign first_err_data = '0;
`endif

endmodule

// File: tb/tb_mem_bist.sv
// tb_mem_bist: randomized self-checking bench for mem_bist with a RAM model
// that can inject read-side stuck-at faults, and a pattern/error reference.
`timescale 1ns/1ps
module tb_mem_bist;

  localparam int DW   = 8;
  localparam int AW   = 16;
  localparam int D    = 16;
  localparam int BASE = 16'h0100;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [1:0]    mode;
  logic          busy, cpu_hold, done, pass;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we, mem_oe;
  logic [DW-1:0] mem_rdata;
  logic [15:0]   err_count;
  logic [AW-1:0] first_err_addr;
  logic [DW-1:0] first_err_data;

  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [DW-1:0] f_and = '1;
  logic [DW-1:0] f_or  = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_bist #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(D), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .busy(busy), .cpu_hold(cpu_hold), .done(done), .pass(pass),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_oe(mem_oe),
    .mem_rdata(mem_rdata), .err_count(err_count),
    .first_err_addr(first_err_addr), .first_err_data(first_err_data)
  );

  // RAM: combinational read with optional stuck-at faults, clocked write
  assign mem_rdata = mem_oe ? ((ram[mem_addr] & f_and) | f_or) : '0;
  always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;

  function automatic logic [DW-1:0] ref_pat(input int m, input int i);
    int v;
    case (m)
      0:       v = ((1 << DW) - 1) - (i % (1 << DW));
      1:       v = i % (1 << DW);
      2:       v = (((BASE + i) % 2) == 0) ? 'h55 : 'hAA;
      default: v = 1 << (i % DW);
    endcase
    return DW'(v);
  endfunction

  // Expected diagnostics for a full run under the current fault masks
  task automatic model_run(input int m, output int ecnt, output int faddr, output int fdata,
                           output bit epass);
    logic [DW-1:0] p, r;
    ecnt = 0; faddr = 0; fdata = 0;
    for (int i = 0; i < D; i++) begin
      p = ref_pat(m, i);
      r = (p & f_and) | f_or;
      if (r != p) begin
        if (ecnt == 0) begin faddr = BASE + i; fdata = int'(r); end
        ecnt++;
      end
    end
    epass = (ecnt == 0);
`ifndef MEM_BIST_ERR_LOG_EN
    ecnt = 0; faddr = 0; fdata = 0;
`endif
  endtask

  task automatic prefill();
    for (int i = -2; i < D + 2; i++) ram[BASE + i] = DW'($urandom);
  endtask

  // Launch one test and follow it cycle by cycle until done; counts busy
  // cycles and any bus-sequence deviations from the expected sweep
  task automatic do_run(input int m, input int pulse_at, output int bcnt, output int prot,
                        output bit to);
    @(posedge clk); #1; start = 1'b1; mode = 2'(m);
    @(posedge clk); #1; start = 1'b0; mode = 2'($urandom);
    bcnt = 0; prot = 0; to = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (done === 1'b1) begin to = 1'b0; break; end
      if (busy === 1'b1) bcnt++;
      if (cpu_hold !== busy) prot++;
      if (mem_we === 1'b1 && mem_oe === 1'b1) prot++;
      if (c == 0) begin
        if (mem_we !== 1'b0 || mem_oe !== 1'b0 || done !== 1'b0 || busy !== 1'b1) prot++;
      end else if (c <= D) begin
        if (mem_we !== 1'b1 || mem_oe !== 1'b0 || mem_addr !== AW'(BASE + c - 1) ||
            mem_wdata !== ref_pat(m, c - 1)) prot++;
      end else if (c <= 2 * D) begin
        if (mem_oe !== 1'b1 || mem_we !== 1'b0 || mem_addr !== AW'(BASE + c - 1 - D)) prot++;
      end else if (mem_we !== 1'b0 || mem_oe !== 1'b0) prot++;
      start = (c == pulse_at);
      if (start) mode = 2'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; mode = 2'd0;
    repeat (2) @(posedge clk); #1;
    checks++; if ({busy, cpu_hold, done, pass, mem_we, mem_oe} !== 6'b0) begin errors++; $display("FAIL reset_flags got %b expected 000000", {busy, cpu_hold, done, pass, mem_we, mem_oe}); end
    checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_addr got %0h expected 0", mem_addr); end
    checks++; if (mem_wdata !== '0) begin errors++; $display("FAIL reset_wdata got %0h expected 0", mem_wdata); end
    checks++; if ({err_count, first_err_addr, first_err_data} !== '0) begin errors++; $display("FAIL reset_errlog got %0h/%0h/%0h expected 0", err_count, first_err_addr, first_err_data); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  // Full clean run in a given mode; verifies timing, bus sequence, results,
  // RAM contents inside the window and that neighbours are untouched
  task automatic clean_run(input int m, input int pulse_at, input string tag);
    int bcnt, prot, ecnt, faddr, fdata; bit to, epass;
    logic [DW-1:0] below, above;
    f_and = '1; f_or = '0;
    prefill();
    below = ram[BASE - 1]; above = ram[BASE + D];
    model_run(m, ecnt, faddr, fdata, epass);
    do_run(m, pulse_at, bcnt, prot, to);
    checks++; if (to) begin errors++; $display("FAIL %s_timeout done never rose", tag); end
    checks++; if (bcnt != 2 * D + 1) begin errors++; $display("FAIL %s_busy_len got %0d expected %0d", tag, bcnt, 2 * D + 1); end
    checks++; if (prot != 0) begin errors++; $display("FAIL %s_bus_seq got %0d deviations expected 0", tag, prot); end
    checks++; if (pass !== epass || done !== 1'b1) begin errors++; $display("FAIL %s_pass got pass=%b done=%b expected pass=%b done=1", tag, pass, done, epass); end
    checks++; if (err_count !== 16'(ecnt)) begin errors++; $display("FAIL %s_err_count got %0d expected %0d", tag, err_count, ecnt); end
    for (int i = 0; i < D; i++) begin
      checks++; if (ram[BASE + i] !== ref_pat(m, i)) begin errors++; $display("FAIL %s_ram[%0h] got %0h expected %0h", tag, BASE + i, ram[BASE + i], ref_pat(m, i)); end
    end
    checks++; if (ram[BASE - 1] !== below || ram[BASE + D] !== above) begin errors++; $display("FAIL %s_outside got %0h/%0h expected %0h/%0h", tag, ram[BASE - 1], ram[BASE + D], below, above); end
  endtask

  task automatic test_modes();
    clean_run(0, -1, "mode0");
    clean_run(1, -1, "mode1");
    clean_run(2, -1, "mode2");
    checks++; if (ram[BASE] !== 8'h55 || ram[BASE + 1] !== 8'hAA) begin errors++; $display("FAIL checker_words got %0h/%0h expected 55/aa", ram[BASE], ram[BASE + 1]); end
    clean_run(3, -1, "mode3");
    clean_run(int'($urandom_range(0, 3)), -1, "mode_rand");
  endtask

  task automatic fault_run(input int m, input string tag);
    int bcnt, prot, ecnt, faddr, fdata; bit to, epass;
    prefill();
    model_run(m, ecnt, faddr, fdata, epass);
    do_run(m, -1, bcnt, prot, to);
    checks++; if (to || bcnt != 2 * D + 1) begin errors++; $display("FAIL %s_timing got busy=%0d timeout=%b expected %0d", tag, bcnt, to, 2 * D + 1); end
    checks++; if (pass !== epass) begin errors++; $display("FAIL %s_pass got %b expected %b", tag, pass, epass); end
    checks++; if (err_count !== 16'(ecnt)) begin errors++; $display("FAIL %s_err_count got %0d expected %0d", tag, err_count, ecnt); end
    checks++; if (first_err_addr !== AW'(faddr)) begin errors++; $display("FAIL %s_first_addr got %0h expected %0h", tag, first_err_addr, faddr); end
    checks++; if (first_err_data !== DW'(fdata)) begin errors++; $display("FAIL %s_first_data got %0h expected %0h", tag, first_err_data, fdata); end
  endtask

  task automatic test_stuck_fault();
    f_and = ~8'h04; f_or = '0;
    fault_run(3, "stuck_bit2");
    for (int k = 0; k < 4; k++) begin
      if ($urandom_range(0, 1) == 1) begin f_and = ~(DW'(1) << $urandom_range(0, DW - 1)); f_or = '0; end
      else begin f_and = '1; f_or = DW'(1) << $urandom_range(0, DW - 1); end
      fault_run(int'($urandom_range(0, 3)), "rand_fault");
    end
    f_and = '1; f_or = '0;
  endtask

  task automatic test_start_while_busy();
    clean_run(int'($urandom_range(0, 3)), 20, "start_in_read");
    clean_run(int'($urandom_range(0, 3)), int'($urandom_range(0, 2 * D)), "start_in_busy");
  endtask

  task automatic test_done_restart();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL done_level got done=%b busy=%b expected 1/0", done, busy); end
    clean_run(1, -1, "restart");
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1; start = 1'b1; mode = 2'd1;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL mid_in_write got we=%b expected 1", mem_we); end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if ({busy, cpu_hold, done, pass, mem_we, mem_oe} !== 6'b0 || mem_addr !== '0 || mem_wdata !== '0) begin errors++; $display("FAIL mid_reset got flags=%b addr=%0h wdata=%0h expected 0", {busy, cpu_hold, done, pass, mem_we, mem_oe}, mem_addr, mem_wdata); end
    reset = 1'b0;
    clean_run(0, -1, "after_reset");
  endtask

  task automatic test_start_reset_together();
    @(posedge clk); #1; reset = 1'b1; start = 1'b1; mode = 2'd2;
    @(posedge clk); #1; reset = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || cpu_hold !== 1'b0 || mem_we !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL start_with_reset got busy=%b hold=%b we=%b done=%b expected 0", busy, cpu_hold, mem_we, done); end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_stuck_fault();
    test_start_while_busy();
    test_done_restart();
    test_reset_mid();
    test_start_reset_together();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bist.md
# mem_bist

Hardware memory self-test engine: the synthesizable, parametrised successor to the bench-side memory sweep check. On `start` it holds the CPU and takes the RAM address/data/strobe lines. It then writes a selectable pattern across a configurable address window, reads the window back and compares each word, and reports pass/fail plus error diagnostics. It sits between the control unit and RAM as a second bus master, selected by `cpu_hold`.

## Interface
- `DATA_WIDTH`, 8, memory word width (≥2)
- `ADDR_WIDTH`, 16, address bus width
- `DEPTH`, 32768, words tested; `BASE_ADDR + DEPTH ≤ 2^ADDR_WIDTH`
- `BASE_ADDR`, 0, first tested address
- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle request; ignored while `busy`
- `mode`  in  2  pattern select, sampled with `start`
- `busy`  out  1  test in progress
- `cpu_hold`  out  1  pauses CPU timer/decoder; equals `busy`
- `done`  out  1  level; set at test end, cleared by next accepted `start`
- `pass`  out  1  valid when `done`; 1 = zero mismatches
- `mem_addr`  out  ADDR_WIDTH  RAM address
- `mem_wdata`  out  DATA_WIDTH  RAM write data
- `mem_we`  out  1  write strobe
- `mem_oe`  out  1  read enable
- `mem_rdata`  in  DATA_WIDTH  RAM read data, combinational from `mem_addr`/`mem_oe`
- `err_count`  out  16  mismatches, saturating
- `first_err_addr`  out  ADDR_WIDTH  address of first mismatch
- `first_err_data`  out  DATA_WIDTH  data read at first mismatch

## Operation
- States: IDLE → HOLD → WRITE → READ → DONE → (IDLE on next `start`, same as from IDLE).
- IDLE/DONE: accepted `start` latches `mode`, clears `err_count`, `done`, `pass`, error capture, index i=0; go HOLD.
- HOLD: one cycle, `cpu_hold`=1, strobes low (lets CPU bus drivers release).
- WRITE: per cycle `mem_addr`=BASE_ADDR+i, `mem_wdata`=P(i), `mem_we`=1; i++; after i=DEPTH-1 reset i=0, go READ.
- READ: per cycle `mem_addr`=BASE_ADDR+i, `mem_oe`=1; at the edge compare `mem_rdata` with P(i); on mismatch increment `err_count` (saturate at 16'hFFFF), capture addr/data if first; after i=DEPTH-1 go DONE.
- DONE: `busy`=`cpu_hold`=0, `done`=1, `pass`=(err_count==0) including the final-cycle compare.
- Pattern P(i), width DATA_WIDTH, i truncated to DATA_WIDTH:
  - mode 0: ~i (all-ones minus index)
  - mode 1: i
  - mode 2: checkerboard, 0101… if address bit0=0 else 1010…
  - mode 3: walking one, 1 << (i mod DATA_WIDTH)
- Index counter is $clog2(DEPTH)+1 bits wide; no address wrap inside window.

## Timing
- Reset values: state IDLE, all outputs 0, `mem_addr`=0.
- `start` at edge n → HOLD in cycle n+1, first write cycle n+2.
- `busy` high for exactly 1+2·DEPTH cycles; `done` rises the cycle after the last read.
- `mem_we`/`mem_oe` never both high; both low outside WRITE/READ.
- `start` while busy: ignored, no effect on counters.
- Reset mid-test: immediate abort to reset values, CPU released; RAM contents undefined.
- `start` and `reset` together: reset wins.

## Configuration
- `MEM_BIST_ERR_LOG_EN` defined: `err_count`, `first_err_addr`, `first_err_data` implemented as above.
- Undefined: those three outputs tied to 0; a single sticky mismatch flag drives `pass`. All other behaviour unchanged.

## Structure
- Package `mem_bist_pkg`: state enum (IDLE, HOLD, WRITE, READ, DONE), mode encodings (MODE_INV_IDX=0, MODE_IDX=1, MODE_CHECKER=2, MODE_WALK1=3), error-counter width constant.
- Sub-module `mem_bist_pattern`: combinational P(i) from `mode`, index and address bit0; shared by write and compare paths.

## Test plan
- DEPTH=16, BASE_ADDR=0, mode 0, ideal RAM → writes 8'hFF..8'hF0 at 0..15, `busy` 33 cycles, `done`=1, `pass`=1, `err_count`=0.
- DEPTH=16, BASE_ADDR=16'h0100, mode 2 → addr 0x0100 gets 8'h55, 0x0101 8'hAA; words outside 0x0100–0x010F untouched.
- Mode 3 with RAM model forcing bit 2 stuck-at-0 → errors at i=2,10; `err_count`=2, `first_err_addr`=0x0002, `first_err_data`=8'h00, `pass`=0.
- Assert `reset` at cycle 10 of WRITE → next cycle all outputs 0 and `cpu_hold`=0; subsequent `start` runs a full clean test.
- Pulse `start` again during READ → ignored, `busy` length still 33 cycles; `start` in DONE clears `done`.
- Build without `MEM_BIST_ERR_LOG_EN`, same stuck-at fault → `pass`=0, `err_count`/`first_err_*` read 0.
